// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit range limits and load-value sanitising helper.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic bcd_t bcd_sanitize(input bcd_t nibble);
        return (nibble > BCD_MAX) ? BCD_MIN : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with clear/load/step; carry_out is combinational.
// Latency: q updates on the edge ending the step cycle; no backpressure.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ld,
    input  bcd_t ld_val,
    input  logic step_in,
    input  logic up,
    output bcd_t q,
    output logic carry_out
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_MIN;
        end else if (ld) begin
            q_d = bcd_sanitize(ld_val);
        end else if (step_in) begin
            if (up) begin
                q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign carry_out = step_in & (up ? (q_q == BCD_MAX) : (q_q == BCD_MIN));

endmodule

// File: rtl/bcd_scan_counter.sv
// Prescaled up/down BCD counter with time-multiplexed digit/anode scan output.
// Latency: digits/wrap one edge after the step cycle, scan outputs registered; no backpressure.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 up,
    input  logic                 clear,
    input  logic                 load,
    input  logic [4*NDIGITS-1:0] load_val,
    output logic [4*NDIGITS-1:0] digits,
    output logic [3:0]           digit_code,
    output logic [NDIGITS-1:0]   anode_n,
    output logic                 wrap
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS  > 1) ? $clog2(NDIGITS)  : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGITS - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    bcd_t          digit_code_q, digit_code_d;
    logic [NDIGITS-1:0] anode_n_q, anode_n_d;
    logic          wrap_q;

    logic          step;
    logic          step_eff;
    bcd_t          digit_q [NDIGITS];
    logic [NDIGITS:0] carry;

    // Prescaler: clear/load restart the period so a fresh value gets a full step interval.
    assign step     = en && (tick_cnt_q == TICK_LAST);
    assign step_eff = step && !clear && !load;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear || load) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = step ? '0 : tick_cnt_q + TW'(1);
        end
    end

    assign carry[0] = step_eff;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clear),
            .ld        (load),
            .ld_val    (load_val[4*i +: 4]),
            .step_in   (carry[i]),
            .up        (up),
            .q         (digit_q[i]),
            .carry_out (carry[i+1])
        );
        assign digits[4*i +: 4] = digit_q[i];
    end

    // Scan outputs are registered from the next index so anode and code move together.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        digit_code_d = digit_q[idx_d];
        anode_n_d    = ~(NDIGITS'(1) << idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            digit_code_q <= BCD_MIN;
            anode_n_q    <= ~NDIGITS'(1);
            wrap_q       <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            digit_code_q <= digit_code_d;
            anode_n_q    <= anode_n_d;
            wrap_q       <= carry[NDIGITS];
        end
    end

    assign digit_code = digit_code_q;
    assign anode_n    = anode_n_q;
    assign wrap       = wrap_q;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit decimal counter with built-in display scanning. It sits directly upstream of the 4-bit to 7-segment decoder.
- Counts in BCD at a prescaled rate, up or down, and supports clear and parallel load.
- Time-multiplexes its digits onto one 4-bit digit_code bus, which feeds the decoder input.
- Provides an active-low one-hot anode select for the common-anode display.

Parameters:
- NDIGITS, 4: number of BCD digits counted and scanned (1..8).
- TICK_DIV, 50000000: clk cycles per count step (1 Hz at 50 MHz). Minimum 1.
- SCAN_DIV, 50000: clk cycles each digit stays selected (1 kHz at 50 MHz). Minimum 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; gates the prescaler only, scanning always runs.
- up  in  1  1 = increment, 0 = decrement; sampled on each count step.
- clear  in  1  synchronous clear of digits and prescaler.
- load  in  1  synchronous parallel load.
- load_val  in  4*NDIGITS  BCD value to load, digit 0 in bits [3:0].
- digits  out  4*NDIGITS  current BCD count, digit 0 least significant.
- digit_code  out  4  BCD nibble of the currently scanned digit, to the decoder.
- anode_n  out  NDIGITS  active-low one-hot select of the scanned digit.
- wrap  out  1  one-cycle pulse on full-range overflow or underflow.

Behaviour:
- Reset (async, rst_n=0):
  - digits=0, digit_code=0, anode_n=~1 (digit 0 low, others high), wrap=0.
  - Prescaler and scan counters = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1 and holds while en=0.
  - Internal step pulse fires in the cycle the count equals TICK_DIV-1, and the count wraps to 0 in that same cycle.
- Priority each cycle: clear > load > step.
  - clear: digits=0, prescaler=0, wrap=0.
  - load: each nibble of load_val >9 is replaced by 0, then written to digits; prescaler=0; wrap=0.
  - step, up=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit (ripple carry within the same cycle). All digits at 9 go to all 0 and wrap=1 for one cycle.
  - step, up=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. All digits at 0 go to all 9 and wrap=1.
- Count update latency: digits change on the clk edge that ends the step cycle. wrap is registered and coincides with the new digits value.
- Digit range: internal digits are always 0..9. Sanitising on load guarantees no invalid nibble ever reaches the decoder.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 independently of en, clear and load.
  - On terminal count, the digit index advances 0,1,..,NDIGITS-1,0.
  - digit_code and anode_n are registered from the same index, so they always change on the same edge and never disagree.
  - digit_code reflects the current digits register with at most one cycle of lag.
- Simultaneous events:
  - clear or load in the step cycle suppresses the step; no wrap pulse.
  - A toggle of up between steps takes effect at the next step.
- Reset mid-operation: all state returns to reset values immediately. Counting resumes from 0 one full TICK_DIV period after rst_n deasserts with en=1.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_t (logic [3:0]).
  - constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
  - function bcd_sanitize (nibble >9 returns 0).
- Sub-module bcd_digit, one per digit via generate.
  - Inputs: clk, rst_n, clr, ld, ld_val, step_in, up.
  - Outputs: q, carry_out.
  - carry_out is combinational: step_in & (up ? q==9 : q==0).
  - Digit i+1 takes step_in from carry_out of digit i. wrap is the registered carry_out of the top digit.
- Prescaler, scan counter and anode decode stay in the top level.

Test Plan (bench uses NDIGITS=4, TICK_DIV=4, SCAN_DIV=2):
- Reset check: hold rst_n=0 3 cycles, release -> digits=16'h0000, anode_n=4'b1110, digit_code=0, wrap=0.
- Up count with carry: load 16'h0099, en=1, up=1, wait 4 cycles -> digits=16'h0100; 36 more steps -> 16'h0136.
- Overflow: load 16'h9999, up=1, one step -> digits=16'h0000, wrap=1 for exactly one cycle.
- Underflow: load 16'h0000, up=0, one step -> digits=16'h9999, wrap pulse. Next step -> 16'h9998, no pulse.
- Load sanitising and priority:
  - load 16'hA5F3 -> digits=16'h0503.
  - Assert clear and load together -> digits=16'h0000.
  - Assert load in the step cycle -> digits=load value, no step.
- Scan: load 16'h4321, en=0, observe 16 cycles -> (anode_n, digit_code) sequence (1110,1),(1101,2),(1011,3),(0111,4), each held 2 cycles then repeating. anode_n stays one-hot-low every cycle.
